// File: rtl/dmsc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmsc_pkg : shared demosaic constants and Bayer colour-type helper
// Rev 1.0
// ----------------------------------------------------------------------------
package dmsc_pkg;

  localparam logic [1:0] CT_R = 2'b00;
  localparam logic [1:0] CT_G = 2'b01;
  localparam logic [1:0] CT_B = 2'b10;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  // x0/y0 are the coordinate parities of the pixel of interest
  function automatic logic [1:0] bayer_ctype(input logic x0, input logic y0,
                                             input logic [1:0] phase);
    logic cx;
    logic cy;
    cx = x0 ^ phase[0];
    cy = y0 ^ phase[1];
    case ({cy, cx})
      2'b00:   return CT_R;
      2'b11:   return CT_B;
      default: return CT_G;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmsc_line_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmsc_line_ram : single-port line buffer, asynchronous read, synchronous write
// Rev 1.0
// ----------------------------------------------------------------------------
module dmsc_line_ram #(
  parameter int PIX_W  = 12,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PIX_W-1:0]  i_wdata,
  output logic [PIX_W-1:0]  o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmsc_window_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmsc_window_gen : 3x3 Bayer window generator with coordinates and backpressure
// Rev 1.0
// ----------------------------------------------------------------------------
module dmsc_window_gen
  import dmsc_pkg::*;
#(
  parameter int PIX_W       = 12,
  parameter int MAX_WIDTH   = 4096,
  parameter int COORD_W     = 12,
  parameter int BORDER_MODE = BORDER_ZERO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W:0]   cfg_width,
  input  logic [1:0]         cfg_bayer,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_data,
  input  logic               s_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [9*PIX_W-1:0] m_win,
  output logic [COORD_W-1:0] m_x,
  output logic [COORD_W-1:0] m_y,
  output logic               m_full,
  output logic [1:0]         m_ctype
);

  localparam logic [COORD_W:0] c_min_width = (COORD_W+1)'(3);
  localparam logic [COORD_W:0] c_max_width = (COORD_W+1)'(MAX_WIDTH);
  localparam bit               c_repl      = (BORDER_MODE == BORDER_REPL);

  logic               r_valid;
  logic               r_full;
  logic [1:0]         r_ctype;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W:0]   r_width;
  logic [PIX_W-1:0]   r_win [3][3];

  logic               w_accept;
  logic               w_last;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W:0]   w_width_clamp;
  logic [PIX_W-1:0]   w_lb_a;
  logic [PIX_W-1:0]   w_lb_b;
  logic [PIX_W-1:0]   w_new [3];

  assign s_ready  = !r_valid || m_ready;
  assign w_accept = s_valid && s_ready;
  assign w_last   = ({1'b0, r_x} == (r_width - 1'b1));

  always_comb begin
    w_width_clamp = cfg_width;
    if (cfg_width < c_min_width)      w_width_clamp = c_min_width;
    else if (cfg_width > c_max_width) w_width_clamp = c_max_width;
  end

  always_comb begin
    w_x = r_x + 1'b1;
    w_y = r_y;
    if (s_sof) begin
      w_x = '0;
      w_y = '0;
    end else if (w_last) begin
      w_x = '0;
      w_y = r_y + 1'b1;
    end
  end

  dmsc_line_ram #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .ADDR_W(COORD_W)) u_lb_a (
    .clock   (clock),
    .i_we    (w_accept && !reset),
    .i_addr  (w_x),
    .i_wdata (s_data),
    .o_rdata (w_lb_a)
  );

  dmsc_line_ram #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .ADDR_W(COORD_W)) u_lb_b (
    .clock   (clock),
    .i_we    (w_accept && !reset),
    .i_addr  (w_x),
    .i_wdata (w_lb_a),
    .o_rdata (w_lb_b)
  );

  // Rows above the frame top hide whatever the line buffers still hold
  always_comb begin
    w_new[0] = w_lb_b;
    w_new[1] = w_lb_a;
    w_new[2] = s_data;
    if (w_y == '0) begin
      w_new[0] = c_repl ? s_data : '0;
      w_new[1] = c_repl ? s_data : '0;
    end else if (w_y == COORD_W'(1)) begin
      w_new[0] = c_repl ? w_lb_a : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_ctype <= CT_R;
      r_x     <= '0;
      r_y     <= '0;
      r_width <= w_width_clamp;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_x     <= w_x;
      r_y     <= w_y;
      r_full  <= (w_x >= COORD_W'(2)) && (w_y >= COORD_W'(2));
      // parity of (x-1)/(y-1) is the inverse of the parity of x/y
      r_ctype <= bayer_ctype(~w_x[0], ~w_y[0], cfg_bayer);
      if (s_sof) r_width <= w_width_clamp;
      for (int r = 0; r < 3; r++) begin
        r_win[r][2] <= w_new[r];
        if (w_x == '0) begin
          r_win[r][1] <= c_repl ? w_new[r] : '0;
          r_win[r][0] <= c_repl ? w_new[r] : '0;
        end else begin
          r_win[r][1] <= r_win[r][2];
          r_win[r][0] <= r_win[r][1];
        end
      end
    end else if (m_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_valid = r_valid;
  assign m_x     = r_x;
  assign m_y     = r_y;
  assign m_full  = r_full;
  assign m_ctype = r_ctype;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign m_win[(8-(r*3+c))*PIX_W +: PIX_W] = r_win[r][c];
    end
  end

endmodule
`default_nettype wire
